// File: rtl/calc_display_if.sv
// Digit-stream and display-drive signals between the calculator core and the display back-end.
interface calc_display_if;
   logic [1:0] status;
   logic [3:0] data;
   logic [3:0] pos;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       upd;

   modport master (output status, data, pos, input an, seg, dp, upd);
   modport slave  (input status, data, pos, output an, seg, dp, upd);
endinterface

// File: rtl/calc_display.sv
// Calculator display back-end: captures the serialised digit stream into a double-buffered
// 8-digit frame and scans it onto eight common-anode seven-segment displays.
module calc_display #(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_ZEROS = 1'b1
) (
   input logic           clock,
   input logic           reset,
   calc_display_if.slave io_bus
);
   localparam int                DIV_W    = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;

   logic [3:0]       r_stage [8];
   logic [3:0]       r_disp  [8];
   logic             r_commit;
   logic             r_upd;
   logic             r_err;
   logic [DIV_W-1:0] r_div_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_an;
   logic [6:0]       r_seg;

   logic             w_cap;
   logic [2:0]       w_wr_idx;
   logic [3:0]       w_digit;
   logic             w_upper_zero;
   logic [6:0]       w_glyph;

   function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
      case (d)
         4'd0:    bcd_glyph = 7'h40;
         4'd1:    bcd_glyph = 7'h79;
         4'd2:    bcd_glyph = 7'h24;
         4'd3:    bcd_glyph = 7'h30;
         4'd4:    bcd_glyph = 7'h19;
         4'd5:    bcd_glyph = 7'h12;
         4'd6:    bcd_glyph = 7'h02;
         4'd7:    bcd_glyph = 7'h78;
         4'd8:    bcd_glyph = 7'h00;
         4'd9:    bcd_glyph = 7'h10;
         default: bcd_glyph = SEG_BLANK;
      endcase
   endfunction

   // Sample k+1 on pos carries digit k; "pronto" and out-of-range positions are ignored.
   assign w_cap    = (io_bus.status != 2'b10) && (io_bus.pos != 4'd0) && (io_bus.pos <= 4'd8);
   assign w_wr_idx = 3'(io_bus.pos - 4'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: these 8x4 arrays are reset because the first scan must show a defined "0";
         // a real RAM would be left unreset.
         r_stage  <= '{default: '0};
         r_disp   <= '{default: '0};
         r_commit <= 1'b0;
         r_upd    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         // NOTE: non-blocking, so a commit on the same edge as a capture copies stage as it
         // stood before this edge's write.
         if (w_cap) r_stage[w_wr_idx] <= io_bus.data;
         if (r_commit) r_disp <= r_stage;
         r_commit <= w_cap && (io_bus.pos == 4'd8);
         r_upd    <= r_commit;
         if (io_bus.status == 2'b00) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_idx     <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
         r_idx     <= r_idx + 3'd1;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      w_digit      = r_disp[r_idx];
      w_upper_zero = 1'b1;
      w_glyph      = SEG_BLANK;
      for (int i = 0; i < 8; i++) begin
         if ((3'(i) >= r_idx) && (r_disp[i] != 4'd0)) w_upper_zero = 1'b0;
      end
      if (r_err) begin
         case (r_idx)
            3'd3:    w_glyph = SEG_E;
            3'd2:    w_glyph = SEG_R;
            3'd1:    w_glyph = SEG_R;
            3'd0:    w_glyph = SEG_O;
            default: w_glyph = SEG_BLANK;
         endcase
      end else if (w_digit > 4'd9) begin
         w_glyph = SEG_BLANK;
      end else if (BLANK_ZEROS && (r_idx != 3'd0) && w_upper_zero) begin
         w_glyph = SEG_BLANK;
      end else begin
         w_glyph = bcd_glyph(w_digit);
      end
   end

   // Anode and segments share one register stage so they always describe the same digit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_an  <= 8'hFF;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= ~(8'd1 << r_idx);
         r_seg <= w_glyph;
      end
   end

   assign io_bus.an  = r_an;
   assign io_bus.seg = r_seg;
   assign io_bus.dp  = 1'b1;
   assign io_bus.upd = r_upd;
endmodule

// File: tb/tb_calc_display.sv
// Randomised self-checking bench for calc_display against a frame/scan-time reference model,
// with two instances covering leading-zero blanking on and off.
module tb_calc_display;
   localparam int R = 4;

   typedef logic [6:0] seg8_t [8];

   localparam logic [6:0] DIGIT_GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   localparam logic [6:0] ERRO_GLYPH  [4]  = '{7'h23, 7'h2F, 7'h2F, 7'h06};

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] status = 2'b10;
   logic [3:0] data = 4'd0;
   logic [3:0] pos = 4'd0;

   calc_display_if bus_bz ();
   calc_display_if bus_all ();

   assign bus_bz.status  = status;
   assign bus_bz.data    = data;
   assign bus_bz.pos     = pos;
   assign bus_all.status = status;
   assign bus_all.data   = data;
   assign bus_all.pos    = pos;

   calc_display #(.REFRESH_DIV(R), .BLANK_ZEROS(1'b1)) dut_bz  (.clock(clock), .reset(reset), .io_bus(bus_bz));
   calc_display #(.REFRESH_DIV(R), .BLANK_ZEROS(1'b0)) dut_all (.clock(clock), .reset(reset), .io_bus(bus_all));

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int upd_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frame buffers as plain arrays, scan slot derived from the edge count.
   int         m_stage [8];
   int         m_disp  [8];
   bit         m_err;
   bit         m_commit;
   int         m_edges;
   logic [7:0] e_an = 8'hFF;
   logic [6:0] e_seg_bz = 7'h7F;
   logic [6:0] e_seg_all = 7'h7F;
   logic       e_upd = 1'b0;

   function automatic logic [6:0] model_glyph(input int slot, input bit bz);
      int upper;
      if (m_err) return (slot < 4) ? ERRO_GLYPH[slot] : 7'h7F;
      if (m_disp[slot] > 9) return 7'h7F;
      if (bz && slot > 0) begin
         upper = 0;
         for (int j = slot; j < 8; j++) upper += m_disp[j];
         if (upper == 0) return 7'h7F;
      end
      return DIGIT_GLYPH[m_disp[slot]];
   endfunction

   task automatic model_step();
      int  slot;
      bit  cap;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_stage[i] = 0;
            m_disp[i]  = 0;
         end
         m_err = 0; m_commit = 0; m_edges = 0;
         e_an = 8'hFF; e_seg_bz = 7'h7F; e_seg_all = 7'h7F; e_upd = 1'b0;
      end else begin
         slot      = (m_edges / R) % 8;
         e_an      = ~(8'd1 << slot);
         e_seg_bz  = model_glyph(slot, 1'b1);
         e_seg_all = model_glyph(slot, 1'b0);
         e_upd     = m_commit;
         if (m_commit) m_disp = m_stage;
         cap = (status != 2'b10) && (pos >= 1) && (pos <= 8);
         if (cap) m_stage[int'(pos) - 1] = int'(data);
         m_commit = cap && (pos == 4'd8);
         if (status == 2'b00) m_err = 1;
         m_edges++;
      end
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clock);
      check("an_bz",   bus_bz.an,   e_an);
      check("an_all",  bus_all.an,  e_an);
      check("seg_bz",  bus_bz.seg,  e_seg_bz);
      check("seg_all", bus_all.seg, e_seg_all);
      check("upd",     bus_bz.upd,  e_upd);
      check("dp",      bus_all.dp,  1'b1);
      if (bus_bz.upd === 1'b1) upd_cnt++;
   end

   task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
      @(negedge clock);
      status = st;
      pos    = p;
      data   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(2'b10, 4'd0, 4'd0);
   endtask

   task automatic send_frame(input logic [31:0] dig, input logic [1:0] st);
      for (int k = 0; k < 8; k++) drive(st, 4'(k + 1), dig[k*4 +: 4]);
      idle(1);
   endtask

   // Walks the scan through all eight slots and pins each glyph to a literal value.
   task automatic check_scan(input string tag, input seg8_t x_bz, input seg8_t x_all);
      logic [7:0] want;
      int         waited;
      @(negedge clock);
      for (int s = 0; s < 8; s++) begin
         want   = ~(8'd1 << s);
         waited = 0;
         while (bus_bz.an !== want && waited < 8 * R + 4) begin
            @(negedge clock);
            waited++;
         end
         if (waited >= 8 * R + 4) begin
            check({tag, "_slot_timeout"}, bus_bz.an, want);
         end else begin
            check({tag, "_bz"},  bus_bz.seg,  x_bz[s]);
            check({tag, "_all"}, bus_all.seg, x_all[s]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      seg8_t x_bz, x_all;
      int    u0;

      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      x_bz  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      x_all = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      check_scan("reset_scan", x_bz, x_all);

      // Asynchronous reset in the middle of a clock period.
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_an",  bus_bz.an,  8'hFF);
      check("async_seg", bus_bz.seg, 7'h7F);
      @(negedge clock);
      reset = 1'b0;

      u0 = upd_cnt;
      send_frame(32'h0001_2345, 2'b01);
      idle(2);
      check("frame_upd_count", upd_cnt - u0, 1);
      x_bz  = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F};
      x_all = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40};
      check_scan("frame12345", x_bz, x_all);

      u0 = upd_cnt;
      for (int k = 0; k < 5; k++) drive(2'b01, 4'(k + 1), 4'd9);
      idle(4);
      check("partial_upd_count", upd_cnt - u0, 0);
      check_scan("partial", x_bz, x_all);

      drive(2'b10, 4'd3, 4'd7);
      drive(2'b01, 4'd0, 4'd5);
      drive(2'b01, 4'd12, 4'd5);
      send_frame(32'h000C_0931, 2'b11);
      idle(2);
      x_bz  = '{7'h79, 7'h30, 7'h10, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      x_all = '{7'h79, 7'h30, 7'h10, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h40};
      check_scan("ignored", x_bz, x_all);

      for (int f = 0; f < 40; f++) begin
         logic [31:0] dig;
         logic [1:0]  st;
         int          stop;
         int          nz;
         dig = '0;
         nz  = $urandom_range(1, 8);
         for (int k = 0; k < nz; k++)
            dig[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
         st   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
         stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
         for (int k = 0; k < stop; k++) drive(st, 4'(k + 1), dig[k*4 +: 4]);
         case ($urandom_range(0, 2))
            0: ;
            1: idle($urandom_range(1, 3));
            default:
               repeat ($urandom_range(1, 3))
                  drive(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                        4'($urandom_range(0, 15)), 4'($urandom));
         endcase
      end
      idle(8 * R + 2);

      drive(2'b00, 4'd0, 4'd0);
      idle(3);
      x_bz  = '{7'h23, 7'h2F, 7'h2F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      x_all = x_bz;
      check_scan("erro", x_bz, x_all);
      u0 = upd_cnt;
      send_frame(32'h8765_4321, 2'b01);
      idle(2);
      check("erro_upd_count", upd_cnt - u0, 1);
      check_scan("erro_held", x_bz, x_all);
      drive(2'b00, 4'd5, 4'd4);
      idle(8 * R);

      @(negedge clock);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      x_bz  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      x_all = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      check_scan("post_reset", x_bz, x_all);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
